// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: FSM state encoding plus small integer helpers shared by the arbiter files
package bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_BEGIN, BUSY} state_e;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_priority_select.sv
// rr_priority_select: picks first requester at/after ptr_i (wrapping); request_i,ptr_i in -> one-hot sel_o, index idx_o out
module rr_priority_select
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         request_i,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr_i,
  output logic [NUM_MASTERS-1:0]         sel_o,
  output logic [$clog2(NUM_MASTERS)-1:0] idx_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  always_comb begin
    idx_o = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (request_i[IW'(wrap_add(int'(ptr_i), k, NUM_MASTERS))]) idx_o = IW'(wrap_add(int'(ptr_i), k, NUM_MASTERS));
    sel_o = |request_i ? NUM_MASTERS'(1) << idx_o : '0;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with grant/transaction watchdogs; request->granted pulse, begin/end strobes in, forced end/error pulses, active_master and bus_idle out
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS   = 4,
  parameter int GRANT_TIMEOUT = 16,
  parameter int BUS_TIMEOUT   = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         request,
  output logic [NUM_MASTERS-1:0]         granted,
  input  logic                           begin_transaction_in,
  input  logic                           end_transaction_in,
  output logic                           end_transaction_out,
  output logic                           bus_error_out,
  output logic [$clog2(NUM_MASTERS)-1:0] active_master,
  output logic                           bus_idle
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(max_i(GRANT_TIMEOUT, BUS_TIMEOUT) + 1);
  state_e                 state_q;
  logic [IW-1:0]          ptr_q, active_q, sel_idx;
  logic [CW-1:0]          gcnt_q, bcnt_q;
  logic [NUM_MASTERS-1:0] granted_q, sel;
  logic                   end_q, err_q, idle_q;
  rr_priority_select #(.NUM_MASTERS(NUM_MASTERS)) u_sel (
    .request_i(request),
    .ptr_i    (ptr_q),
    .sel_o    (sel),
    .idx_o    (sel_idx)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      active_q  <= '0;
      gcnt_q    <= '0;
      bcnt_q    <= '0;
      granted_q <= '0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      granted_q <= '0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: if (|request) begin
          granted_q <= sel;
          active_q  <= sel_idx;
          idle_q    <= 1'b0;
          ptr_q     <= sel_idx == IW'(NUM_MASTERS - 1) ? '0 : sel_idx + 1'b1;
          gcnt_q    <= '0;
          state_q   <= WAIT_BEGIN;
        end
        WAIT_BEGIN: if (begin_transaction_in) begin
          bcnt_q  <= '0;
          state_q <= BUSY;
        end else if (gcnt_q == CW'(GRANT_TIMEOUT - 1)) begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          gcnt_q <= gcnt_q + CW'(~&gcnt_q);
        end
        BUSY: if (end_transaction_in) begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end else if (bcnt_q == CW'(BUS_TIMEOUT - 1)) begin
          end_q   <= 1'b1;
          err_q   <= 1'b1;
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          bcnt_q <= bcnt_q + CW'(~&bcnt_q);
        end
        default: begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign granted             = granted_q;
  assign end_transaction_out = end_q;
  assign bus_error_out       = err_q;
  assign active_master       = active_q;
  assign bus_idle            = idle_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: deadline-based reference model with per-cycle compare, directed scenarios and random traffic
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int GT = 16;
  localparam int BT = 256;
  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] request, granted;
  logic         begin_transaction_in, end_transaction_in;
  logic         end_transaction_out, bus_error_out, bus_idle;
  logic [1:0]   active_master;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  bus_arbiter #(.NUM_MASTERS(N), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT)) dut (
    .clock               (clock),
    .reset               (reset),
    .request             (request),
    .granted             (granted),
    .begin_transaction_in(begin_transaction_in),
    .end_transaction_in  (end_transaction_in),
    .end_transaction_out (end_transaction_out),
    .bus_error_out       (bus_error_out),
    .active_master       (active_master),
    .bus_idle            (bus_idle)
  );
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // model: mode 0 free, 1 granted awaiting begin, 2 transaction running; deadline = last edge on which the phase may still complete
  int mode = 0, ptr = 0, deadline = 0, cyc = 0, exp_grant = 0, exp_active = 0;
  bit exp_end = 0, exp_err = 0, exp_idle = 1, started = 0;
  function automatic int pick(input int r, input int p);
    for (int k = 0; k < N; k++) if (((r >> ((p + k) % N)) % 2) == 1) return (p + k) % N;
    return -1;
  endfunction
  always @(posedge clock) begin
    exp_grant = 0;
    exp_end   = 0;
    exp_err   = 0;
    if (reset) begin
      mode = 0; ptr = 0; exp_active = 0; exp_idle = 1; started = 1;
    end else if (mode == 0) begin
      if (pick(int'(request), ptr) >= 0) begin
        exp_active = pick(int'(request), ptr);
        exp_grant  = 1 << exp_active;
        exp_idle   = 0;
        ptr        = (exp_active + 1) % N;
        mode       = 1;
        deadline   = cyc + GT;
      end
    end else if (mode == 1) begin
      if (begin_transaction_in) begin
        mode = 2; deadline = cyc + BT;
      end else if (cyc == deadline) begin
        mode = 0; exp_idle = 1;
      end
    end else begin
      if (end_transaction_in) begin
        mode = 0; exp_idle = 1;
      end else if (cyc == deadline) begin
        mode = 0; exp_idle = 1; exp_end = 1; exp_err = 1;
      end
    end
    cyc++;
  end
  always @(negedge clock) if (started) begin
    cmp("granted", 32'(granted), 32'(exp_grant));
    cmp("end_out", 32'(end_transaction_out), 32'(exp_end));
    cmp("bus_error", 32'(bus_error_out), 32'(exp_err));
    cmp("bus_idle", 32'(bus_idle), 32'(exp_idle));
    if (!exp_idle) cmp("active_master", 32'(active_master), 32'(exp_active));
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1; request = '0; begin_transaction_in = 1'b0; end_transaction_in = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask
  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (granted != '0) begin
        g = granted;
        return;
      end
    end
    cmp("grant_timeout", 32'(0), 32'(1));
  endtask
  task automatic do_xact();
    step();
    begin_transaction_in = 1'b1;
    step();
    begin_transaction_in = 1'b0;
    repeat (3) step();
    end_transaction_in = 1'b1;
    step();
    end_transaction_in = 1'b0;
  endtask
  logic [N-1:0] g;
  int n;
  initial begin
    do_reset();
    request = 4'b0001;
    wait_grant(g);
    cmp("t1_grant", 32'(g), 32'h1);
    step();
    request = '0;
    begin_transaction_in = 1'b1;
    step();
    begin_transaction_in = 1'b0;
    repeat (4) step();
    end_transaction_in = 1'b1;
    step();
    end_transaction_in = 1'b0;
    @(negedge clock);
    cmp("t1_idle_after_end", 32'(bus_idle), 32'h1);
    do_reset();
    request = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      cmp("t2_order", 32'(g), 32'(1 << (i % N)));
      do_xact();
    end
    do_reset();
    request = 4'b0100;
    wait_grant(g);
    cmp("t3_grant", 32'(g), 32'h4);
    request = '0;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (bus_idle) break;
    end
    cmp("t3_wait_len", 32'(n), 32'(GT));
    cmp("t3_no_err", 32'(bus_error_out), 32'h0);
    step();
    request = 4'b0110;
    wait_grant(g);
    cmp("t3_wrap_grant", 32'(g), 32'h2);
    request = '0;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      request = 4'b0100;
      wait_grant(g);
      step();
      request = '0;
      begin_transaction_in = 1'b1;
      step();
      begin_transaction_in = 1'b0;
      if (t == 0) begin
        n = 0;
        while (n < 300) begin
          @(negedge clock);
          n++;
          if (end_transaction_out) break;
        end
        cmp("t4_pulse_cycle", 32'(n), 32'(BT + 1));
        cmp("t4_err_with_end", 32'(bus_error_out), 32'h1);
        @(negedge clock);
        cmp("t4_idle_next", 32'(bus_idle), 32'h1);
        cmp("t4_pulse_len", 32'(end_transaction_out), 32'h0);
      end else begin
        repeat (BT - 1) step();
        end_transaction_in = 1'b1;
        step();
        end_transaction_in = 1'b0;
        @(negedge clock);
        cmp("t5_no_forced_end", 32'(end_transaction_out), 32'h0);
        cmp("t5_no_err", 32'(bus_error_out), 32'h0);
        cmp("t5_idle", 32'(bus_idle), 32'h1);
      end
    end
    do_reset();
    request = 4'b0001;
    wait_grant(g);
    step();
    request = '0;
    begin_transaction_in = 1'b1;
    step();
    begin_transaction_in = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    request = 4'b0010;
    repeat (2) step();
    reset = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clock);
      n++;
      if (granted != '0) break;
    end
    cmp("t6_grant_delay", 32'(n), 32'h2);
    cmp("t6_grant", 32'(granted), 32'h2);
    step();
    request = '0;
    repeat (20) step();
    for (int i = 0; i < 6000; i++) begin
      if (i % 8 == 0) request = N'($urandom_range(0, 15));
      begin_transaction_in = $urandom_range(0, 5) == 0;
      end_transaction_in   = $urandom_range(0, 20) == 0;
      reset                = $urandom_range(0, 1499) == 0;
      step();
    end
    reset = 1'b0;
    request = '0;
    begin_transaction_in = 1'b0;
    end_transaction_in = 1'b0;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
